gbt_tx_frameclk_pll_rst_ctrl: RTL



---
 rtl/gbt_tx_frameclk_pll_rst_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gbt_tx_frameclk_pll_rst_ctrl.sv
// rtl/gbt_tx_frameclk_pll_rst_ctrl.sv - TX frame-clock PLL reset sequencer and lock supervisor (optional macro: GBT_TX_PLL_LOL_FILTER_EN)
module gbt_tx_frameclk_pll_rst_ctrl #(
    parameter int unsigned RST_PULSE_CYC    = 120,
    parameter int unsigned LOCK_TIMEOUT_CYC = 120000,
    parameter int unsigned LOCK_STABLE_CYC  = 1200,
    parameter int unsigned MAX_RETRIES      = 7,
    parameter int unsigned LOL_FILTER_CYC   = 4
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        locked_i,
    input  logic        manual_rst_i,
    output logic        pll_rst_o,
    output logic        frameclk_ready_o,
    output logic        lock_fail_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] lol_cnt_o
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_FAIL
    } state_t;

    localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]  RETRY_MAX    = 8'(MAX_RETRIES);

    // Without the filter, one low sample of locked_s in READY is enough to act.
`ifdef GBT_TX_PLL_LOL_FILTER_EN
    localparam int unsigned LOL_LEN = (LOL_FILTER_CYC == 0) ? 1 : LOL_FILTER_CYC;
`else
    localparam int unsigned LOL_LEN = 1;
`endif
    localparam int unsigned FILT_W   = (LOL_FILTER_CYC > 1) ? $clog2(LOL_FILTER_CYC) : 1;
    localparam logic [FILT_W-1:0] LOL_LAST = FILT_W'(LOL_LEN - 1);
    localparam logic [FILT_W-1:0] FILT_ONE = FILT_W'(1);

    state_t              state;
    logic [31:0]         timer;
    logic                sync_q1;
    logic                locked_s;
    logic [FILT_W-1:0]   lol_filt;

    // Two-flop synchronizer bringing the PLL lock flag into the refclk domain.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= locked_i;
            locked_s <= sync_q1;
        end
    end

    // Sequencer: reset pulse, lock wait with retries, stability qualification, lock supervision.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_RESET_PLL;
            timer            <= 32'd0;
            lol_filt         <= '0;
            pll_rst_o        <= 1'b1;
            frameclk_ready_o <= 1'b0;
            lock_fail_o      <= 1'b0;
            retry_cnt_o      <= 8'd0;
            lol_cnt_o        <= 16'd0;
        end else if (manual_rst_i) begin
            // Restart from any state; the loss-of-lock history is kept.
            state            <= S_RESET_PLL;
            timer            <= 32'd0;
            lol_filt         <= '0;
            pll_rst_o        <= 1'b1;
            frameclk_ready_o <= 1'b0;
            lock_fail_o      <= 1'b0;
            retry_cnt_o      <= 8'd0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (timer == RST_LAST) begin
                        state     <= S_WAIT_LOCK;
                        timer     <= 32'd0;
                        pll_rst_o <= 1'b0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock is checked first so it wins on the timeout cycle.
                    if (locked_s) begin
                        state <= S_STABLE;
                        timer <= 32'd0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer <= 32'd0;
                        if (retry_cnt_o == RETRY_MAX) begin
                            state       <= S_FAIL;
                            lock_fail_o <= 1'b1;
                        end else begin
                            state       <= S_RESET_PLL;
                            retry_cnt_o <= retry_cnt_o + 8'd1;
                            pll_rst_o   <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_STABLE: begin
                    // A glitch goes back to waiting with a fresh timeout; it is not a retry.
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        timer <= 32'd0;
                    end else if (timer == STABLE_LAST) begin
                        state            <= S_READY;
                        timer            <= 32'd0;
                        lol_filt         <= '0;
                        frameclk_ready_o <= 1'b1;
                        retry_cnt_o      <= 8'd0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        if (lol_filt == LOL_LAST) begin
                            state            <= S_RESET_PLL;
                            timer            <= 32'd0;
                            lol_filt         <= '0;
                            pll_rst_o        <= 1'b1;
                            frameclk_ready_o <= 1'b0;
                            if (lol_cnt_o != 16'hFFFF) begin
                                lol_cnt_o <= lol_cnt_o + 16'd1;
                            end
                        end else begin
                            lol_filt <= lol_filt + FILT_ONE;
                        end
                    end else begin
                        lol_filt <= '0;
                    end
                end
                S_FAIL: begin
                    // Parked until manual_rst_i or rst_n; late locks are ignored.
                    pll_rst_o        <= 1'b0;
                    frameclk_ready_o <= 1'b0;
                    lock_fail_o      <= 1'b1;
                end
                default: begin
                    state     <= S_RESET_PLL;
                    timer     <= 32'd0;
                    pll_rst_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
